// File: rtl/gv_pkg.sv
// Shared game definitions: mode codes from the game controller, the beat
// sequencer state encoding and the datapath widths used across the block.
package gv_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd1,
    MODE_EDIT   = 3'd2,
    MODE_DIFF   = 3'd3,
    MODE_RUN    = 3'd4,
    MODE_PAUSE  = 3'd5,
    MODE_FINISH = 3'd6
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  localparam int PERIOD_W = 23;
  localparam int POS_W    = 6;

  // A beat interval shorter than two cycles would make beats continuous.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat interval timer: latches the effective period at round load, counts
// cycles while running, flags the terminal count and the hit window.
module beat_timer
  import gv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                window
);

  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] quarter;
  logic                terminal;

  assign terminal = (count == eff_period - 1'b1);
  assign quarter  = eff_period >> 2;

  // Period latch and cycle counter; the counter freezes whenever run is low.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      eff_period <= PERIOD_W'(2);
      count      <= '0;
    end else if (load) begin
      eff_period <= clamp_period(period);
      count      <= '0;
    end else if (run) begin
      if (terminal) count <= '0;
      else          count <= count + 1'b1;
    end
  end

  assign tick   = run && terminal;
  assign window = (count < quarter) || (count >= eff_period - quarter);

endmodule

// File: rtl/beat_sequencer.sv
// Rhythm game beat sequencer: scrolls two note lanes toward the hit row one
// step per beat, drains the lanes after the last song step and flags the end.
module beat_sequencer
  import gv_pkg::*;
#(
  parameter int NOTES    = 32,
  parameter int LANE_LEN = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NOTES-1:0]    song_a,
  input  logic [NOTES-1:0]    song_b,
  output logic                beat,
  output logic [POS_W-1:0]    position,
  output logic [LANE_LEN-1:0] lane_a,
  output logic [LANE_LEN-1:0] lane_b,
  output logic                window,
  output logic                finish
);

  localparam int              NOTE_IDX_W = $clog2(NOTES);
  localparam logic [POS_W-1:0] LAST_NOTE = POS_W'(NOTES - 1);
  localparam logic [POS_W-1:0] LAST_BEAT = POS_W'(NOTES + LANE_LEN - 1);

  seq_state_e state, state_d, resume;
  logic       is_run, is_pause;
  logic       run, load, tick, timer_window;
  logic       in_a, in_b;

  assign is_run   = (mode == MODE_RUN);
  assign is_pause = (mode == MODE_PAUSE);

  beat_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .load   (load),
    .period (period),
    .tick   (tick),
    .window (timer_window)
  );

  // State register plus the state to return to when a pause ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      resume <= S_PLAY;
    end else begin
      state <= state_d;
      if (state_d == S_HOLD && state != S_HOLD) resume <= state;
    end
  end

  // Next-state decode from mode and beat progress.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      S_IDLE: if (is_run) state_d = S_PLAY;
      S_PLAY, S_DRAIN: begin
        if (is_pause)                         state_d = S_HOLD;
        else if (!is_run)                     state_d = S_IDLE;
        else if (tick && position == LAST_BEAT) state_d = S_DONE;
        else if (tick && position == LAST_NOTE) state_d = S_DRAIN;
      end
      S_HOLD: begin
        if (is_run)         state_d = resume;
        else if (!is_pause) state_d = S_IDLE;
      end
      S_DONE: if (!is_run && !is_pause) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the current state and mode.
  always_comb begin
    run    = (state == S_PLAY || state == S_DRAIN) && is_run;
    load   = (state == S_IDLE) && is_run;
    finish = tick && (state == S_DRAIN) && (position == LAST_BEAT);
  end

  assign beat   = tick;
  // The counter is frozen during a pause, so the window holds its last value.
  assign window = timer_window && (state inside {S_PLAY, S_DRAIN, S_HOLD});

  // Drain beats feed empty steps so the remaining notes scroll out.
  assign in_a = (state == S_PLAY) ? song_a[position[NOTE_IDX_W-1:0]] : 1'b0;
  assign in_b = (state == S_PLAY) ? song_b[position[NOTE_IDX_W-1:0]] : 1'b0;

  // Lane scroll and step position: cleared at load or abort, shifted per beat.
  always_ff @(posedge clk) begin
    if (rst || load || state_d == S_IDLE) begin
      lane_a   <= '0;
      lane_b   <= '0;
      position <= '0;
    end else if (tick) begin
      lane_a   <= {lane_a[LANE_LEN-2:0], in_a};
      lane_b   <= {lane_b[LANE_LEN-2:0], in_b};
      position <= position + 1'b1;
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with a scoreboard of per-beat expectations.
module tb_beat_sequencer;
  import gv_pkg::*;

  localparam int NOTES    = 32;
  localparam int LANE_LEN = 7;
  localparam int ROUND    = NOTES + LANE_LEN;
  localparam int BUDGET   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          mode;
  logic [22:0]         period;
  logic [31:0]         song_a, song_b;
  logic                beat, window, finish;
  logic [5:0]          position;
  logic [LANE_LEN-1:0] lane_a, lane_b;

  typedef struct {
    int                  pos;
    logic [LANE_LEN-1:0] la;
    logic [LANE_LEN-1:0] lb;
    logic                fin;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  beat_sequencer #(.NOTES(NOTES), .LANE_LEN(LANE_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .period   (period),
    .song_a   (song_a),
    .song_b   (song_b),
    .beat     (beat),
    .position (position),
    .lane_a   (lane_a),
    .lane_b   (lane_b),
    .window   (window),
    .finish   (finish)
  );

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane contents after k beats: bit j holds song step k-1-j if that step exists.
  function automatic logic [LANE_LEN-1:0] lane_after(input logic [31:0] song, input int k);
    lane_after = '0;
    for (int j = 0; j < LANE_LEN; j++) begin
      int idx;
      idx = k - 1 - j;
      if (idx >= 0 && idx < NOTES) lane_after[j] = song[idx];
    end
  endfunction

  task automatic push_round(input logic [31:0] sa, input logic [31:0] sbits);
    for (int k = 1; k <= ROUND; k++) begin
      exp_t e;
      e.pos = k;
      e.la  = lane_after(sa, k);
      e.lb  = lane_after(sbits, k);
      e.fin = (k == ROUND);
      sb.push_back(e);
    end
  endtask

  // Drive a new round from S_IDLE; returns just after the load edge.
  task automatic start_round(input logic [31:0] sa, input logic [31:0] sbits, input logic [22:0] per);
    sb.delete();
    song_a = sa;
    song_b = sbits;
    period = per;
    mode   = MODE_RUN;
    push_round(sa, sbits);
    @(posedge clk); #1;
  endtask

  // Pop the next expectation at a beat, then check the registered lanes.
  task automatic after_beat(input string tag);
    exp_t e;
    check(sb.size() > 0, 1'b1, {tag, " scoreboard has entry"});
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check(finish, e.fin, {tag, " finish"});
    @(posedge clk); #1;
    check(position, e.pos, {tag, " position"});
    check(lane_a, e.la, {tag, " lane_a"});
    check(lane_b, e.lb, {tag, " lane_b"});
  endtask

  task automatic consume_beat(input int exp_gap, input string tag);
    int gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (beat !== 1'b1 && gap < BUDGET);
    check(gap, exp_gap, {tag, " beat gap"});
    after_beat(tag);
  endtask

  task automatic abort_round(input string tag);
    mode = MODE_IDLE;
    @(posedge clk); #1;
    check(position, 0, {tag, " abort position"});
    check({lane_a, lane_b}, '0, {tag, " abort lanes"});
    sb.delete();
  endtask

  initial begin
    int extra;
    rst    = 1'b1;
    mode   = MODE_IDLE;
    period = '0;
    song_a = '0;
    song_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check(beat, 1'b0, "reset beat");
    check(finish, 1'b0, "reset finish");
    check(window, 1'b0, "reset window");
    check(position, 0, "reset position");
    check({lane_a, lane_b}, '0, "reset lanes");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single note on lane A reaches the hit row after seven beats.
    start_round(32'h1, 32'h0, 23'd4);
    for (int b = 1; b <= 7; b++) consume_beat(4, "r1");
    check(lane_a[LANE_LEN-1], 1'b1, "r1 hit row after 7 beats");
    consume_beat(4, "r1");
    abort_round("r1");

    // Full round at period 3: 39 beats, finish on the last, then silence.
    start_round(32'hA5C3_0F96, 32'h8000_0001, 23'd3);
    for (int b = 1; b <= ROUND; b++) consume_beat(3, "r2");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (beat !== 1'b0 || finish !== 1'b0) extra++;
    end
    check(extra, 0, "r2 beats after done");
    check(position, ROUND, "r2 done position");
    check({lane_a, lane_b}, '0, "r2 done lanes");
    abort_round("r2");

    // Periods below two clamp to a two-cycle beat.
    start_round(32'hFFFF_FFFF, 32'h5555_5555, 23'd0);
    for (int b = 1; b <= 3; b++) consume_beat(2, "p0");
    abort_round("p0");
    start_round(32'h0F0F_0F0F, 32'hF0F0_F0F0, 23'd1);
    for (int b = 1; b <= 3; b++) consume_beat(2, "p1");
    abort_round("p1");

    // Window over one period-16 interval, then a mid-round period change.
    start_round(32'h3, 32'hC, 23'd16);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check(window, (k - 1 < 4) || (k - 1 >= 12), $sformatf("w16 window count %0d", k - 1));
      check(beat, k == 16, $sformatf("w16 beat count %0d", k - 1));
    end
    after_beat("w16");
    period = 23'd5;
    consume_beat(16, "w16 period ignored");
    abort_round("w16");

    // Pause on the terminal count suppresses the beat; resume fires it.
    start_round(32'h0000_00FF, 32'h0, 23'd8);
    consume_beat(8, "ps");
    repeat (7) @(posedge clk);
    #1;
    mode = MODE_PAUSE;
    @(negedge clk);
    check(beat, 1'b0, "ps entry beat");
    check(window, 1'b1, "ps entry window");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (beat !== 1'b0) extra++;
    end
    check(extra, 0, "ps beats while held");
    check(position, 1, "ps held position");
    @(posedge clk); #1;
    mode = MODE_RUN;
    @(posedge clk); #1;
    consume_beat(1, "ps resume");
    consume_beat(8, "ps after resume");
    abort_round("ps");

    // Reset while draining clears everything; the round then reloads.
    start_round(32'hDEAD_BEEF, 32'h1234_5678, 23'd2);
    for (int b = 1; b <= NOTES + 1; b++) consume_beat(2, "rd");
    rst = 1'b1;
    @(posedge clk); #1;
    check(beat, 1'b0, "rd reset beat");
    check(finish, 1'b0, "rd reset finish");
    check(window, 1'b0, "rd reset window");
    check(position, 0, "rd reset position");
    check({lane_a, lane_b}, '0, "rd reset lanes");
    rst = 1'b0;
    sb.delete();
    push_round(song_a, song_b);
    @(posedge clk); #1;
    for (int b = 1; b <= 3; b++) consume_beat(2, "rd reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
